// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry block: key codes, state and
// operator encodings, display digit constants and the display formatter.
package calc_pkg;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_EQU       = 4'd14;
  localparam logic [3:0] KEY_CLR       = 4'd15;

  localparam logic [3:0] BLANK_DIGIT   = 4'hF;
  localparam logic [3:0] ERR_DIGIT     = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPA   = 3'd1,
    S_OPSEL = 3'd2,
    S_OPB   = 3'd3,
    S_CALC  = 3'd4,
    S_SHOW  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  function automatic op_e key_to_op(input logic [3:0] key);
    op_e op;
    case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // Right-aligned BCD over ndig digits (max 8); leading zeros blank, 0 shows "0".
  function automatic logic [31:0] bin_to_bcd(input logic [31:0] value, input int ndig);
    logic [31:0] v;
    logic [31:0] bcd;
    v   = value;
    bcd = {8{BLANK_DIGIT}};
    for (int i = 0; i < 8; i++) begin
      if ((i < ndig) && ((i == 0) || (v != 32'd0))) begin
        bcd[4*i +: 4] = 4'(v % 32'd10);
      end else begin
        bcd[4*i +: 4] = BLANK_DIGIT;
      end
      v = v / 32'd10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Multi-cycle arithmetic unit: shift-add multiply, restoring divide, and
// add/subtract held so that every operation completes in AW cycles.
module calc_alu
  import calc_pkg::*;
#(
  parameter int AW = 7,
  parameter int RW = 2*AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  op_e           i_op,
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_b,
  output logic          o_done,
  output logic [RW-1:0] o_res,
  output logic          o_neg
);

  localparam int CW = $clog2(AW+1);

  logic          r_busy;
  logic          r_done;
  logic          r_neg;
  logic [CW-1:0] r_cnt;
  op_e           r_op;
  logic [RW-1:0] r_acc;
  logic [RW-1:0] r_mcand;
  logic [AW-1:0] r_q;

  logic          w_ld;
  logic [CW-1:0] w_cnt_nxt;
  op_e           w_op;
  logic [RW-1:0] w_acc;
  logic [RW-1:0] w_mcand;
  logic [AW-1:0] w_q;
  logic [AW:0]   w_rem;
  logic [RW-1:0] s_acc;
  logic [RW-1:0] s_mcand;
  logic [AW-1:0] s_q;

  // The load edge also performs the first iteration, so AW steps fit in AW cycles.
  always_comb begin
    w_ld      = i_start && !r_busy;
    w_cnt_nxt = w_ld ? CW'(1) : (r_cnt + CW'(1));
    w_op      = r_op;
    w_acc     = r_acc;
    w_mcand   = r_mcand;
    w_q       = r_q;
    if (w_ld) begin
      w_op    = i_op;
      w_acc   = {RW{1'b0}};
      w_mcand = RW'(i_a);
      w_q     = i_b;
      case (i_op)
        OP_ADD: w_acc = RW'(i_a) + RW'(i_b);
        OP_SUB: begin
          if (i_a >= i_b) begin
            w_acc = RW'(i_a - i_b);
          end else begin
            w_acc = RW'(i_b - i_a);
          end
        end
        OP_DIV: begin
          w_mcand = RW'(i_b);
          w_q     = i_a;
        end
        default: w_acc = {RW{1'b0}};
      endcase
    end else begin
      w_op = r_op;
    end

    w_rem   = {w_acc[AW-1:0], w_q[AW-1]};
    s_acc   = w_acc;
    s_mcand = w_mcand;
    s_q     = w_q;
    case (w_op)
      OP_MUL: begin
        if (w_q[0]) begin
          s_acc = w_acc + w_mcand;
        end else begin
          s_acc = w_acc;
        end
        s_mcand = {w_mcand[RW-2:0], 1'b0};
        s_q     = {1'b0, w_q[AW-1:1]};
      end
      OP_DIV: begin
        if (w_rem >= {1'b0, w_mcand[AW-1:0]}) begin
          s_acc = RW'(w_rem - {1'b0, w_mcand[AW-1:0]});
          s_q   = {w_q[AW-2:0], 1'b1};
        end else begin
          s_acc = RW'(w_rem);
          s_q   = {w_q[AW-2:0], 1'b0};
        end
      end
      default: s_acc = w_acc;
    endcase
  end

  // Iteration registers; abort drops an operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_op    <= OP_ADD;
      r_acc   <= {RW{1'b0}};
      r_mcand <= {RW{1'b0}};
      r_q     <= {AW{1'b0}};
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_ld || r_busy) begin
      r_op    <= w_op;
      r_acc   <= s_acc;
      r_mcand <= s_mcand;
      r_q     <= s_q;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_cnt_nxt != CW'(AW));
      r_done  <= (w_cnt_nxt == CW'(AW));
      if (w_ld) begin
        r_neg <= (i_op == OP_SUB) && (i_a < i_b);
      end else begin
        r_neg <= r_neg;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done = r_done;
  assign o_res  = (r_op == OP_DIV) ? RW'(r_q) : r_acc;
  assign o_neg  = r_neg;

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator key-entry controller: collects two operands and an operator from
// a keypad, runs the ALU and formats operands/results for a BCD display.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int AW     = $clog2(10**DIGITS),
  parameter int RW     = 2*AW
) (
  input  logic                  press_clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [8*DIGITS-1:0]   disp_bcd,
  output logic [2:0]            stage,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  neg,
  output logic                  err
);

  state_e        r_state;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic [2:0]    r_cnt;
  op_e           r_op;
  logic [RW-1:0] r_res;

  state_e        w_nxt_state;
  logic [AW-1:0] w_nxt_a;
  logic [AW-1:0] w_nxt_b;
  logic [2:0]    w_nxt_cnt;
  op_e           w_nxt_op;
  logic          w_nxt_neg;
  logic [RW-1:0] w_nxt_res;
  logic [RW-1:0] w_disp_val;
  logic [8*DIGITS-1:0] w_nxt_disp;
  logic          w_start;
  logic          w_abort;
  logic          w_alu_done;
  logic [RW-1:0] w_alu_res;
  logic          w_alu_neg;

  logic          w_key_dig;
  logic          w_key_op;
  logic          w_key_equ;
  logic          w_key_clr;
  logic          w_room;
  logic [AW-1:0] w_digit;

  assign w_key_dig = key_valid && (key_code <= KEY_MAX_DIGIT);
  assign w_key_op  = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign w_key_equ = key_valid && (key_code == KEY_EQU);
  assign w_key_clr = key_valid && (key_code == KEY_CLR);
  assign w_room    = (r_cnt < 3'(DIGITS));
  assign w_digit   = AW'(key_code);

  calc_alu #(.AW(AW), .RW(RW)) u_alu (
    .i_clk   (press_clk),
    .i_rst   (rst),
    .i_start (w_start),
    .i_abort (w_abort),
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_done  (w_alu_done),
    .o_res   (w_alu_res),
    .o_neg   (w_alu_neg)
  );

  // Next-state and datapath updates; CLR takes priority over everything, including ALU done.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_a     = r_a;
    w_nxt_b     = r_b;
    w_nxt_cnt   = r_cnt;
    w_nxt_op    = r_op;
    w_nxt_neg   = neg;
    w_nxt_res   = r_res;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    if (w_key_clr) begin
      w_nxt_state = S_IDLE;
      w_nxt_a     = {AW{1'b0}};
      w_nxt_b     = {AW{1'b0}};
      w_nxt_cnt   = 3'd0;
      w_nxt_op    = OP_ADD;
      w_nxt_neg   = 1'b0;
      w_nxt_res   = {RW{1'b0}};
      w_abort     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_dig) begin
            w_nxt_a     = w_digit;
            w_nxt_cnt   = 3'd1;
            w_nxt_state = S_OPA;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        S_OPA: begin
          if (w_key_dig && w_room) begin
            w_nxt_a   = r_a * AW'(4'd10) + w_digit;
            w_nxt_cnt = r_cnt + 3'd1;
          end else if (w_key_op) begin
            w_nxt_op    = key_to_op(key_code);
            w_nxt_state = S_OPSEL;
          end else begin
            w_nxt_state = S_OPA;
          end
        end
        S_OPSEL: begin
          if (w_key_op) begin
            w_nxt_op = key_to_op(key_code);
          end else if (w_key_dig) begin
            w_nxt_b     = w_digit;
            w_nxt_cnt   = 3'd1;
            w_nxt_state = S_OPB;
          end else begin
            w_nxt_state = S_OPSEL;
          end
        end
        S_OPB: begin
          if (w_key_dig && w_room) begin
            w_nxt_b   = r_b * AW'(4'd10) + w_digit;
            w_nxt_cnt = r_cnt + 3'd1;
          end else if (w_key_equ) begin
            w_start     = 1'b1;
            w_nxt_state = S_CALC;
          end else begin
            w_nxt_state = S_OPB;
          end
        end
        S_CALC: begin
          if (w_alu_done) begin
            if ((r_op == OP_DIV) && (r_b == {AW{1'b0}})) begin
              w_nxt_state = S_ERR;
            end else begin
              w_nxt_res   = w_alu_res;
              w_nxt_neg   = w_alu_neg;
              w_nxt_state = S_SHOW;
            end
          end else begin
            w_nxt_state = S_CALC;
          end
        end
        S_SHOW: begin
          if (w_key_dig) begin
            w_nxt_a     = w_digit;
            w_nxt_cnt   = 3'd1;
            w_nxt_neg   = 1'b0;
            w_nxt_state = S_OPA;
          end else begin
            w_nxt_state = S_SHOW;
          end
        end
        S_ERR:   w_nxt_state = S_ERR;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Display contents follow the state being entered, so the register lands in step with stage.
  always_comb begin
    w_disp_val = {RW{1'b0}};
    case (w_nxt_state)
      S_OPA, S_OPSEL: w_disp_val = RW'(w_nxt_a);
      S_OPB, S_CALC:  w_disp_val = RW'(w_nxt_b);
      S_SHOW:         w_disp_val = w_nxt_res;
      default:        w_disp_val = {RW{1'b0}};
    endcase
    if (w_nxt_state == S_ERR) begin
      w_nxt_disp = {(2*DIGITS){ERR_DIGIT}};
    end else begin
      w_nxt_disp = (8*DIGITS)'(bin_to_bcd(32'(w_disp_val), 2*DIGITS));
    end
  end

  // State, operand registers and registered outputs.
  always_ff @(posedge press_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= {AW{1'b0}};
      r_b          <= {AW{1'b0}};
      r_cnt        <= 3'd0;
      r_op         <= OP_ADD;
      r_res        <= {RW{1'b0}};
      neg          <= 1'b0;
      stage        <= S_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      disp_bcd     <= {{(2*DIGITS-1){BLANK_DIGIT}}, 4'h0};
    end else begin
      r_state      <= w_nxt_state;
      r_a          <= w_nxt_a;
      r_b          <= w_nxt_b;
      r_cnt        <= w_nxt_cnt;
      r_op         <= w_nxt_op;
      r_res        <= w_nxt_res;
      neg          <= w_nxt_neg;
      stage        <= w_nxt_state;
      busy         <= (w_nxt_state == S_CALC);
      result_valid <= (w_nxt_state == S_SHOW);
      err          <= (w_nxt_state == S_ERR);
      disp_bcd     <= w_nxt_disp;
    end
  end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm (DIGITS=2): expected results are queued when
// EQU is pressed and checked when the block reports SHOW or ERR.
module tb_calc_entry_fsm;
  import calc_pkg::*;

  logic        press_clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] disp_bcd;
  logic [2:0]  stage;
  logic        busy;
  logic        result_valid;
  logic        neg;
  logic        err;

  typedef struct packed {
    logic [15:0] disp;
    logic        neg;
    logic        err;
    logic        chk_neg;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rv_seen     = 0;

  calc_entry_fsm dut (
    .press_clk    (press_clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .disp_bcd     (disp_bcd),
    .stage        (stage),
    .busy         (busy),
    .result_valid (result_valid),
    .neg          (neg),
    .err          (err)
  );

  always #5 press_clk = ~press_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge press_clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge press_clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic n, input logic e, input logic cn);
    exp_t x;
    x.disp = d; x.neg = n; x.err = e; x.chk_neg = cn;
    sb.push_back(x);
  endtask

  task automatic wait_result(input string tag);
    int   n     = 0;
    int   busyc = 0;
    exp_t e;
    while (!(result_valid || err) && (n < 40)) begin
      if (busy) busyc++;
      @(negedge press_clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 40), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busyc), 32'd7);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_disp"}, 32'(disp_bcd), 32'(e.disp));
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_rv"}, 32'(result_valid), 32'(!e.err));
      if (e.chk_neg) begin
        chk({tag, "_neg"}, 32'(neg), 32'(e.neg));
      end
    end else begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  task automatic equ_expect(input string tag, input logic [15:0] d, input logic n, input logic e);
    push_exp(d, n, e, !e);
    press(KEY_EQU);
    wait_result(tag);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(negedge press_clk);
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_disp", 32'(disp_bcd), 32'hFFF0);
    @(negedge press_clk);
    rst = 1'b0;

    // 12 + 34
    press(4'd1);
    chk("a1_disp", 32'(disp_bcd), 32'hFFF1);
    chk("a1_stage", 32'(stage), 32'd1);
    press(4'd2);
    chk("a12_disp", 32'(disp_bcd), 32'hFF12);
    press(KEY_ADD);
    chk("opsel_stage", 32'(stage), 32'd2);
    chk("opsel_disp", 32'(disp_bcd), 32'hFF12);
    press(4'd3);
    press(4'd4);
    chk("b34_stage", 32'(stage), 32'd3);
    chk("b34_disp", 32'(disp_bcd), 32'hFF34);
    equ_expect("add", 16'hFF46, 1'b0, 1'b0);
    chk("add_stage", 32'(stage), 32'd5);

    // 05 - 37, entered straight from SHOW
    press(4'd0);
    chk("show_dig_stage", 32'(stage), 32'd1);
    press(4'd5);
    chk("a05_disp", 32'(disp_bcd), 32'hFFF5);
    press(KEY_SUB);
    press(4'd3);
    press(4'd7);
    equ_expect("sub", 16'hFF32, 1'b1, 1'b0);

    // 99 * 99
    press(4'd9);
    press(4'd9);
    press(KEY_MUL);
    press(4'd9);
    press(4'd9);
    equ_expect("mul", 16'h9801, 1'b0, 1'b0);

    // operator and EQU are ignored in SHOW
    press(KEY_ADD);
    chk("show_op_ign", 32'(stage), 32'd5);
    press(KEY_EQU);
    chk("show_equ_ign", 32'(stage), 32'd5);
    chk("show_equ_busy", 32'(busy), 32'd0);

    // 7 / 0
    press(4'd7);
    press(KEY_DIV);
    press(4'd0);
    equ_expect("div0", 16'hEEEE, 1'b0, 1'b1);
    chk("div0_stage", 32'(stage), 32'd6);
    press(4'd5);
    chk("err_dig_ign", 32'(stage), 32'd6);
    press(KEY_CLR);
    chk("clr_stage", 32'(stage), 32'd0);
    chk("clr_disp", 32'(disp_bcd), 32'hFFF0);
    chk("clr_err", 32'(err), 32'd0);

    // third digit dropped; last operator wins
    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk("a123_disp", 32'(disp_bcd), 32'hFF12);
    press(KEY_ADD);
    press(KEY_SUB);
    chk("op_repl_stage", 32'(stage), 32'd2);
    press(4'd4);
    equ_expect("op_repl", 16'hFFF8, 1'b0, 1'b0);

    press(4'd8);
    press(4'd7);
    press(KEY_DIV);
    press(4'd9);
    equ_expect("div", 16'hFFF9, 1'b0, 1'b0);

    press(4'd9);
    press(4'd9);
    press(KEY_ADD);
    press(4'd9);
    press(4'd9);
    equ_expect("add_carry", 16'hF198, 1'b0, 1'b0);

    press(4'd5);
    press(KEY_SUB);
    press(4'd5);
    equ_expect("sub_zero", 16'hFFF0, 1'b0, 1'b0);

    // CLR while the ALU is running
    press(4'd1);
    press(KEY_ADD);
    press(4'd2);
    press(KEY_EQU);
    chk("calc_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge press_clk);
    press(KEY_CLR);
    chk("abort_stage", 32'(stage), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_disp", 32'(disp_bcd), 32'hFFF0);
    for (int i = 0; i < 20; i++) begin
      @(negedge press_clk);
      if (result_valid) rv_seen++;
    end
    chk("abort_no_rv", 32'(rv_seen), 32'd0);

    // reset mid-entry, then a key on the releasing edge
    press(4'd4);
    press(4'd5);
    chk("a45_disp", 32'(disp_bcd), 32'hFF45);
    @(negedge press_clk);
    rst = 1'b1;
    @(negedge press_clk);
    chk("midrst_stage", 32'(stage), 32'd0);
    chk("midrst_disp", 32'(disp_bcd), 32'hFFF0);
    rst       = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'd6;
    @(negedge press_clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    chk("rel_key_stage", 32'(stage), 32'd1);
    chk("rel_key_disp", 32'(disp_bcd), 32'hFFF6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
